// File: rtl/uart_tx_arbiter_if.sv
// Requester, configuration and transmitter-side signals of uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface uart_tx_arbiter_if #(
   parameter int REQ_N = 4,
   parameter int TO_W  = 24
);
   logic [15:0]        cfg_comp;
   logic [1:0]         cfg_stop_sel;
   logic               cfg_en;
   logic [TO_W-1:0]    cfg_to_limit;
   logic [REQ_N-1:0]   req;
   logic [8*REQ_N-1:0] data;
   logic [REQ_N-1:0]   ack;
   logic               err;
   logic [REQ_N-1:0]   owner;
   logic               busy;
   logic [15:0]        comp;
   logic [1:0]         stop_sel;
   logic               tr_en;
   logic [7:0]         tx_data;
   logic               tx_req;
   logic               tx_req_ack;

   modport slave (
      input  cfg_comp, cfg_stop_sel, cfg_en, cfg_to_limit, req, data, tx_req_ack,
      output ack, err, owner, busy, comp, stop_sel, tr_en, tx_data, tx_req
   );

   modport master (
      output cfg_comp, cfg_stop_sel, cfg_en, cfg_to_limit, req, data, tx_req_ack,
      input  ack, err, owner, busy, comp, stop_sel, tr_en, tx_data, tx_req
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among REQ_N byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to build the handshake timeout / abort path.
module uart_tx_arbiter #(
   parameter int REQ_N = 4,
   parameter int TO_W  = 24
) (
   input logic              clk,
   input logic              resetn,
   uart_tx_arbiter_if.slave bus
);
   localparam int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_REL,
      ST_DONE,
      ST_ABORT
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   own_idx_q, own_idx_d;
   logic [REQ_N-1:0]   owner_q, owner_d;
   logic [REQ_N-1:0]   ack_q, ack_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               tr_en_q, tr_en_d;
   logic               tx_req_q, tx_req_d;
   logic [15:0]        comp_q, comp_d;
   logic [1:0]         stop_sel_q, stop_sel_d;
   logic [7:0]         tx_data_q, tx_data_d;

   logic               found;
   logic [IDX_W-1:0]   gnt_idx;
   logic [7:0]         sel_byte;
   logic [IDX_W-1:0]   ptr_next;
   logic               timeout;

   // First set request at or after the pointer, wrapping modulo REQ_N.
   always_comb begin
      int cand;
      logic [IDX_W-1:0] cidx;
      found   = 1'b0;
      gnt_idx = ptr_q;
      cand    = 0;
      cidx    = '0;
      for (int k = 0; k < REQ_N; k++) begin
         cand = (int'(ptr_q) + k) % REQ_N;
         cidx = IDX_W'(cand);
         if (!found && bus.req[cidx]) begin
            found   = 1'b1;
            gnt_idx = cidx;
         end
      end
   end

   always_comb begin
      sel_byte = '0;
      for (int i = 0; i < REQ_N; i++) begin
         if (gnt_idx == IDX_W'(i)) sel_byte = bus.data[8*i +: 8];
      end
   end

   assign ptr_next = (own_idx_q == IDX_W'(REQ_N - 1)) ? '0 : own_idx_q + IDX_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Held at zero while idle, so it starts from zero on every entry to REQ.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == ST_IDLE) begin
         to_cnt_d = '0;
      end else if (state_q == ST_REQ || state_q == ST_REL) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) to_cnt_q <= '0;
      else         to_cnt_q <= to_cnt_d;
   end

   assign timeout = (bus.cfg_to_limit != '0) && (to_cnt_q == bus.cfg_to_limit);
`else
   logic unused_to_limit;
   assign unused_to_limit = ^bus.cfg_to_limit;
   assign timeout         = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      own_idx_d  = own_idx_q;
      comp_d     = comp_q;
      stop_sel_d = stop_sel_q;
      tx_data_d  = tx_data_q;

      unique case (state_q)
         ST_IDLE: begin
            if (found && bus.cfg_en) begin
               state_d    = ST_REQ;
               own_idx_d  = gnt_idx;
               tx_data_d  = sel_byte;
               comp_d     = bus.cfg_comp;
               stop_sel_d = bus.cfg_stop_sel;
            end
         end
         ST_REQ: begin
            if (timeout)             state_d = ST_ABORT;
            else if (bus.tx_req_ack) state_d = ST_REL;
         end
         ST_REL: begin
            if (timeout)              state_d = ST_ABORT;
            else if (!bus.tx_req_ack) state_d = ST_DONE;
         end
         ST_DONE, ST_ABORT: begin
            state_d = ST_IDLE;
            ptr_d   = ptr_next;
         end
         default: state_d = ST_IDLE;
      endcase

      // Disabling abandons the byte silently; the pointer is left alone.
      if (!bus.cfg_en) state_d = ST_IDLE;

      owner_d = '0;
      if (state_d != ST_IDLE) owner_d[own_idx_d] = 1'b1;
      ack_d    = (state_d == ST_DONE || state_d == ST_ABORT) ? owner_d : '0;
      err_d    = (state_d == ST_ABORT);
      busy_d   = (state_d != ST_IDLE);
      tx_req_d = (state_d == ST_REQ);
      tr_en_d  = bus.cfg_en && (state_d != ST_ABORT);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         own_idx_q  <= '0;
         owner_q    <= '0;
         ack_q      <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         tr_en_q    <= 1'b0;
         tx_req_q   <= 1'b0;
         comp_q     <= '0;
         stop_sel_q <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         own_idx_q  <= own_idx_d;
         owner_q    <= owner_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         tr_en_q    <= tr_en_d;
         tx_req_q   <= tx_req_d;
         comp_q     <= comp_d;
         stop_sel_q <= stop_sel_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.ack      = ack_q;
   assign bus.err      = err_q;
   assign bus.owner    = owner_q;
   assign bus.busy     = busy_q;
   assign bus.comp     = comp_q;
   assign bus.stop_sel = stop_sel_q;
   assign bus.tr_en    = tr_en_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_req   = tx_req_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter: a round-robin service-order model
// predicts (owner, byte, comp, err) per acknowledge; a monitor checks each ack pulse.
module tb_uart_tx_arbiter;
   localparam int N    = 4;
   localparam int TO_W = 24;

   logic clk = 1'b0;
   logic resetn;

   uart_tx_arbiter_if #(.REQ_N(N), .TO_W(TO_W)) bus ();
   uart_tx_arbiter #(.REQ_N(N), .TO_W(TO_W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [7:0]  b;
      logic [15:0] comp;
      bit          err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rq[N][$];
   logic [7:0] pl[N][$];
   int         checks = 0;
   int         errors = 0;
   int         m_ptr  = 0;

   int          fixed_delay = -1;
   bit          never_ack   = 1'b0;
   logic [7:0]  cur_byte    = '0;
   logic [15:0] cur_comp    = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Round-robin service order: from the pointer, next requester with bytes left.
   task automatic issue(input logic [15:0] c_first, input logic [15:0] c_rest, input bit first_err);
      int   left[N];
      int   pos[N];
      int   total;
      int   k;
      bit   first;
      exp_t e;
      total = 0;
      first = 1'b1;
      for (int i = 0; i < N; i++) begin
         left[i] = pl[i].size();
         pos[i]  = 0;
         total  += left[i];
      end
      while (total > 0) begin
         k = m_ptr;
         while (left[k] == 0) k = (k + 1) % N;
         e.idx  = k;
         e.b    = pl[k][pos[k]];
         e.comp = first ? c_first : c_rest;
         e.err  = first && first_err;
         exp_q.push_back(e);
         pos[k]++;
         left[k]--;
         total--;
         m_ptr = (k + 1) % N;
         first = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < pl[i].size(); j++) rq[i].push_back(pl[i][j]);
         pl[i].delete();
      end
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || pending()) && n < 3000) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s drain timeout left=%0d required=0", name, exp_q.size());
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic wait_tx_req(input string name);
      int n = 0;
      while (!bus.tx_req && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (!bus.tx_req) begin
         errors++;
         $display("FAIL %s tx_req never rose actual=0 required=1", name);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},      32'(bus.ack),      32'h0);
      check({tag, "_err"},      32'(bus.err),      32'h0);
      check({tag, "_owner"},    32'(bus.owner),    32'h0);
      check({tag, "_busy"},     32'(bus.busy),     32'h0);
      check({tag, "_comp"},     32'(bus.comp),     32'h0);
      check({tag, "_stop_sel"}, 32'(bus.stop_sel), 32'h0);
      check({tag, "_tr_en"},    32'(bus.tr_en),    32'h0);
      check({tag, "_tx_data"},  32'(bus.tx_data),  32'h0);
      check({tag, "_tx_req"},   32'(bus.tx_req),   32'h0);
   endtask

   // Requesters: hold req/data until ack, move to the next byte on the ack cycle.
   initial begin : req_driver
      logic [8*N-1:0] d;
      bus.req  = '0;
      bus.data = '0;
      forever begin
         @(negedge clk);
         d = '0;
         for (int i = 0; i < N; i++) begin
            if (resetn && bus.ack[i] && rq[i].size() != 0) rq[i].delete(0);
            bus.req[i] = (rq[i].size() != 0);
            if (rq[i].size() != 0) d[8*i +: 8] = rq[i][0];
         end
         bus.data = d;
      end
   end

   // Transmitter: captures the byte on tx_req, acks after a delay, releases after tx_req drops.
   initial begin : xmit_model
      int st  = 0;
      int cnt = 0;
      bus.tx_req_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn || !bus.tr_en) begin
            st = 0;
            bus.tx_req_ack = 1'b0;
         end else begin
            case (st)
               0: if (bus.tx_req) begin
                     cur_byte = bus.tx_data;
                     cur_comp = bus.comp;
                     cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 6));
                     st  = 1;
                  end
               1: if (!never_ack) begin
                     if (cnt == 0) begin
                        bus.tx_req_ack = 1'b1;
                        st = 2;
                     end else cnt--;
                  end
               2: if (!bus.tx_req) begin
                     cnt = int'($urandom_range(0, 3));
                     st  = 3;
                  end
               3: if (cnt == 0) begin
                     bus.tx_req_ack = 1'b0;
                     st = 0;
                  end else cnt--;
               default: st = 0;
            endcase
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn && bus.ack != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack actual=%b required=0000", bus.ack);
            end else begin
               e = exp_q.pop_front();
               check("ack_vec",   32'(bus.ack),   32'(1) << e.idx);
               check("ack_owner", 32'(bus.owner), 32'(1) << e.idx);
               check("ack_err",   32'(bus.err),   32'(e.err));
               check("tx_byte",   32'(cur_byte),  32'(e.b));
               check("tx_comp",   32'(cur_comp),  32'(e.comp));
            end
         end else if (resetn && bus.err) begin
            checks++;
            errors++;
            $display("FAIL err_without_ack actual=1 required=0");
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int         n;
      logic [15:0] rc;
      resetn           = 1'b0;
      bus.cfg_comp     = '0;
      bus.cfg_stop_sel = '0;
      bus.cfg_en       = 1'b0;
      bus.cfg_to_limit = '0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");

      resetn           = 1'b1;
      bus.cfg_en       = 1'b1;
      bus.cfg_comp     = 16'h0010;
      bus.cfg_stop_sel = 2'd1;
      @(negedge clk); #1;
      check("tr_en_follows_cfg", 32'(bus.tr_en), 32'h1);

      // Single byte from requester 0, transmitter acks after 20 cycles.
      fixed_delay = 20;
      pl[0].push_back(8'h55);
      issue(16'h0010, 16'h0010, 1'b0);
      wait_tx_req("single");
      check("single_tx_data",  32'(bus.tx_data),  32'h55);
      check("single_owner",    32'(bus.owner),    32'h1);
      check("single_busy",     32'(bus.busy),     32'h1);
      check("single_stop_sel", 32'(bus.stop_sel), 32'h1);
      n = 0;
      while (bus.tx_req && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      check("single_tx_req_hold", 32'(n), 32'd22);
      wait_drain("single");
      check("single_busy_idle",  32'(bus.busy),  32'h0);
      check("single_owner_idle", 32'(bus.owner), 32'h0);
      fixed_delay = -1;

      // Requesters 1 and 3 together: 1 first, then 3 after one idle cycle.
      pl[1].push_back(8'hA1);
      pl[3].push_back(8'hA3);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      n = 0;
      while (bus.ack == '0 && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check("pair_first_ack", 32'(bus.ack), 32'h2);
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!bus.tx_req && n < 20);
      check("pair_grant_gap", 32'(n), 32'd2);
      check("pair_second_owner", 32'(bus.owner), 32'h8);
      wait_drain("pair");

      // Requesters 0 and 2 continuously for three bytes each.
      for (int j = 0; j < 3; j++) begin
         pl[0].push_back(8'(8'h10 + j));
         pl[2].push_back(8'(8'h20 + j));
      end
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      wait_drain("rotation");

      // Divider change while a byte is in flight.
      fixed_delay = 10;
      pl[0].push_back(8'hC0);
      pl[0].push_back(8'hC1);
      issue(16'h0010, 16'h0020, 1'b0);
      wait_tx_req("comp");
      bus.cfg_comp = 16'h0020;
      repeat (2) @(negedge clk);
      #1;
      check("comp_inflight_tx_req", 32'(bus.tx_req), 32'h1);
      check("comp_inflight_value",  32'(bus.comp),   32'h0010);
      wait_drain("comp");
      check("comp_after_regrant", 32'(bus.comp), 32'h0020);
      fixed_delay = -1;

      // Randomized rounds.
      for (int r = 0; r < 8; r++) begin
         rc = 16'($urandom);
         bus.cfg_comp = rc;
         for (int i = 0; i < N; i++) begin
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < n; j++) pl[i].push_back(8'($urandom));
         end
         issue(rc, rc, 1'b0);
         wait_drain("random");
      end

      // Enable dropped mid-byte, pointer must stay on requester 1.
      pl[0].push_back(8'hE0);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      wait_drain("pre_disable");
      fixed_delay = 10;
      rq[1].push_back(8'hE1);
      wait_tx_req("disable");
      check("disable_owner_before", 32'(bus.owner), 32'h2);
      bus.cfg_en = 1'b0;
      @(negedge clk); #1;
      check("disable_tx_req", 32'(bus.tx_req), 32'h0);
      check("disable_tr_en",  32'(bus.tr_en),  32'h0);
      check("disable_owner",  32'(bus.owner),  32'h0);
      check("disable_busy",   32'(bus.busy),   32'h0);
      repeat (5) @(negedge clk);
      #1;
      check("disable_still_pending", 32'(rq[1].size()), 32'd1);
      rq[1].delete();
      pl[1].push_back(8'hE1);
      pl[0].push_back(8'hE2);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      bus.cfg_en = 1'b1;
      wait_tx_req("reenable");
      check("reenable_first_owner", 32'(bus.owner), 32'h2);
      wait_drain("reenable");
      fixed_delay = -1;

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Transmitter never acks: abort after the limit, next requester served normally.
      bus.cfg_to_limit = TO_W'(100);
      never_ack = 1'b1;
      pl[2].push_back(8'hD2);
      pl[3].push_back(8'hD3);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b1);
      wait_tx_req("timeout");
      n = 0;
      while (bus.ack == '0 && n < 300) begin
         @(negedge clk); #1;
         n++;
      end
      check("timeout_cycles", 32'(n),          32'd101);
      check("timeout_err",    32'(bus.err),    32'h1);
      check("timeout_tr_en",  32'(bus.tr_en),  32'h0);
      check("timeout_tx_req", 32'(bus.tx_req), 32'h0);
      never_ack = 1'b0;
      @(negedge clk); #1;
      check("timeout_tr_en_back", 32'(bus.tr_en), 32'h1);
      wait_drain("timeout");
      bus.cfg_to_limit = '0;
`else
      // Without the timeout build the limit has no effect on slow bytes.
      bus.cfg_to_limit = TO_W'(5);
      fixed_delay = 10;
      pl[2].push_back(8'hD2);
      pl[3].push_back(8'hD3);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      wait_drain("no_timeout");
      fixed_delay = -1;
      bus.cfg_to_limit = '0;
`endif

      // Reset mid-byte: outputs clear at once, pointer returns to 0.
      pl[2].push_back(8'hF2);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      wait_drain("pre_reset");
      fixed_delay = 10;
      rq[3].push_back(8'hF3);
      wait_tx_req("reset_mid");
      resetn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      for (int i = 0; i < N; i++) rq[i].delete();
      m_ptr = 0;
      repeat (2) @(negedge clk);
      #1;
      resetn = 1'b1;
      fixed_delay = -1;
      pl[1].push_back(8'hB1);
      pl[3].push_back(8'hB3);
      issue(bus.cfg_comp, bus.cfg_comp, 1'b0);
      wait_drain("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
